// File: rtl/buffer_drain.sv
// Read-side drain for a one-deep buffer: pulls words while there is room and queues them
// in a small circular FIFO presented over valid/ready, with a saturating handshake counter.
module buffer_drain #(
    parameter int DataWidth = 64,
    parameter int Depth     = 2,
    parameter int CntWidth  = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 BufFull,
    output logic                 BufRInc,
    input  logic [DataWidth-1:0] BufRData,
    output logic                 OutValid,
    output logic [DataWidth-1:0] OutData,
    input  logic                 OutReady,
    input  logic                 Flush,
    output logic [CntWidth-1:0]  DrainCount
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = PtrW + 1;

    localparam logic [PtrW-1:0]     PtrOne   = PtrW'(1);
    localparam logic [CntW-1:0]     CountOne = CntW'(1);
    localparam logic [CntW-1:0]     CountMax = CntW'(Depth);
    localparam logic [CntWidth-1:0] DcOne    = CntWidth'(1);
    localparam logic [CntWidth-1:0] DcMax    = {CntWidth{1'b1}};

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wptr_q, wptr_d;
    logic [PtrW-1:0]      rptr_q, rptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [CntWidth-1:0]  drain_q, drain_d;
    logic                 pop_s, push_s, space_s;

    // Handshake decode: a pop frees a slot in the same cycle, so a full queue can still accept.
    always_comb begin
        pop_s   = (count_q != '0) & OutReady & ~Flush;
        space_s = (count_q < CountMax) | pop_s;
        push_s  = BufFull & space_s & ~Flush;
    end

    // Next-state for pointers, occupancy and the delivered-word counter.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        drain_d = drain_q;
        if (Flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_s) begin
                wptr_d = wptr_q + PtrOne;
            end else begin
                wptr_d = wptr_q;
            end
            if (pop_s) begin
                rptr_d = rptr_q + PtrOne;
            end else begin
                rptr_d = rptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CountOne;
                2'b01:   count_d = count_q - CountOne;
                default: count_d = count_q;
            endcase
            if (pop_s && (drain_q != DcMax)) begin
                drain_d = drain_q + DcOne;
            end else begin
                drain_d = drain_q;
            end
        end
    end

    // State registers; storage is cleared on reset so OutData reads zero afterwards.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            drain_q <= '0;
        end else begin
            if (push_s) begin
                mem_q[wptr_q] <= BufRData;
            end
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            drain_q <= drain_d;
        end
    end

    // The read strobe must stay combinational: the buffer only drives data while it is high.
    assign BufRInc    = push_s;
    assign OutValid   = (count_q != '0);
    assign OutData    = mem_q[rptr_q];
    assign DrainCount = drain_q;

endmodule
